level_scroller: RTL and testbench

Parametrised successor to the single-line ground renderer. It draws the dashed scrolling ground, owns NOBS obstacle slots, spawns obstacles into three height lanes from an LFSR, and scrolls them leftward once per frame. It also produces a sticky pixel-exact collision flag and a pass score for the game FSM. It sits between the state machine/VGA timing and the pixel mux, alongside the character sprite block.

---
 rtl/level_scroller.sv | 218 +++++++++++++++++++++
 tb/tb_level_scroller.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/level_scroller.sv
// level_scroller
// Draws the dashed scrolling ground and owns NOBS obstacle slots. Obstacles
// are spawned into three height lanes from a Galois LFSR, scroll left once per
// frame, and retire (scoring a pass) when they leave the left edge. It also
// produces a sticky pixel-exact collision flag against the character sprite.
//
// Ports:
//   Clk          pixel clock
//   Reset        asynchronous active-low reset
//   frame_tick   one-Clk pulse per frame
//   game_run     high while the game is running (freezes state when low)
//   game_restart one-cycle synchronous restart, wins over frame_tick
//   speed        scroll step minus one (step = speed+1 px/frame)
//   hc, vc       current pixel position
//   player_pix   sprite pixel at hc/vc, 0 = transparent
//   level_pix    registered ground/obstacle pixel (1-cycle latency)
//   hit          sticky collision flag (registered)
//   score        obstacles passed, saturating
//   obs_active   slot valid bits
module level_scroller #(
    parameter int          CIDXW    = 3,
    parameter int          CORDW    = 10,
    parameter int          NOBS     = 4,
    parameter int          GROUND_Y = 308,
    parameter int          X_LEFT   = 170,
    parameter int          X_RIGHT  = 750,
    parameter int          OBS_W    = 16,
    parameter int          OBS_H    = 24,
    parameter int          COOLMIN  = 40,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             game_run,
    input  logic             game_restart,
    input  logic [2:0]       speed,
    input  logic [CORDW-1:0] hc,
    input  logic [CORDW-1:0] vc,
    input  logic [CIDXW:0]   player_pix,
    output logic [CIDXW:0]   level_pix,
    output logic             hit,
    output logic [15:0]      score,
    output logic [NOBS-1:0]  obs_active
);
    // Cooldown must hold COOLMIN + 31.
    localparam int CDW = 8;

    localparam logic [CORDW:0]   XL     = (CORDW+1)'(X_LEFT);
    localparam logic [CORDW:0]   XR     = (CORDW+1)'(X_RIGHT);
    localparam logic [CORDW:0]   GY0    = (CORDW+1)'(GROUND_Y);
    localparam logic [CORDW:0]   GY1    = (CORDW+1)'(GROUND_Y + 1);
    localparam logic [CORDW:0]   L1_TOP = (CORDW+1)'(GROUND_Y - OBS_H);
    localparam logic [CORDW:0]   L2_TOP = (CORDW+1)'(GROUND_Y - 2*OBS_H);
    localparam logic [CORDW:0]   L3_TOP = (CORDW+1)'(GROUND_Y - 3*OBS_H);
    localparam logic [CORDW:0]   OBW1   = (CORDW+1)'(OBS_W - 1);
    localparam logic [CORDW:0]   OBH1   = (CORDW+1)'(OBS_H - 1);
    localparam logic [CORDW-1:0] SPAWN_X = CORDW'(X_RIGHT);
    localparam logic [CDW-1:0]   COOL0  = CDW'(COOLMIN);
    localparam logic [CIDXW:0]   GROUND_COL = (CIDXW+1)'(7);

    logic [CORDW-1:0] slot_x    [NOBS];
    logic [1:0]       slot_lane [NOBS];
    logic [2:0]       phase;
    logic [15:0]      lfsr;
    logic [CDW-1:0]   cooldown;

    logic [3:0]       step;
    logic             frame_upd;
    logic [CORDW:0]   hc_w;
    logic [CORDW:0]   vc_w;
    logic             in_cols;
    logic             ground_on;
    logic             obs_match;
    logic [CIDXW:0]   obs_col;

    logic [CORDW-1:0] x_nxt    [NOBS];
    logic [1:0]       lane_nxt [NOBS];
    logic [NOBS-1:0]  act_nxt;
    logic [NOBS-1:0]  first_free;
    logic [3:0]       retire_cnt;
    logic [16:0]      score_sum;
    logic [CDW-1:0]   cd_nxt;
    logic [15:0]      lfsr_nxt;

    function automatic logic [CORDW:0] lane_top(input logic [1:0] lane);
        case (lane)
            2'd1:    lane_top = L1_TOP;
            2'd2:    lane_top = L2_TOP;
            2'd3:    lane_top = L3_TOP;
            default: lane_top = '0;
        endcase
    endfunction

    assign step      = {1'b0, speed} + 4'd1;
    assign frame_upd = frame_tick & game_run & ~game_restart;
    assign hc_w      = {1'b0, hc};
    assign vc_w      = {1'b0, vc};
    assign in_cols   = (hc_w >= XL) && (hc_w <= XR);
    assign ground_on = ((vc_w == GY0) && (hc[2:0] == phase)) ||
                       ((vc_w == GY1) && (hc[2:0] != phase));

    // Galois form, taps 16,14,13,11; a nonzero state never maps to zero.
    assign lfsr_nxt   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    // One-hot of the lowest clear bit; zero when every slot is busy.
    assign first_free = ~obs_active & (obs_active + NOBS'(1));

    // Walk slots from the top down so the lowest-index match wins.
    always_comb begin
        obs_match = 1'b0;
        obs_col   = '0;
        for (int i = NOBS-1; i >= 0; i--) begin
            if (in_cols && obs_active[i] && (slot_lane[i] != 2'd0) &&
                (hc_w >= {1'b0, slot_x[i]}) &&
                (hc_w <= {1'b0, slot_x[i]} + OBW1) &&
                (vc_w >= lane_top(slot_lane[i])) &&
                (vc_w <= lane_top(slot_lane[i]) + OBH1)) begin
                obs_match = 1'b1;
                obs_col   = (CIDXW+1)'(3) + (CIDXW+1)'(slot_lane[i]);
            end
        end
    end

    // Spawn decisions look at the pre-update occupancy, so a slot freed by a
    // retirement this frame cannot be refilled until the next frame.
    always_comb begin
        x_nxt      = slot_x;
        lane_nxt   = slot_lane;
        act_nxt    = obs_active;
        retire_cnt = '0;
        cd_nxt     = cooldown;
        for (int i = 0; i < NOBS; i++) begin
            if (obs_active[i]) begin
                if ({1'b0, slot_x[i]} < XL + (CORDW+1)'(step)) begin
                    act_nxt[i]  = 1'b0;
                    x_nxt[i]    = '0;
                    lane_nxt[i] = '0;
                    retire_cnt  = retire_cnt + 4'd1;
                end else begin
                    x_nxt[i] = slot_x[i] - CORDW'(step);
                end
            end
        end
        if (cooldown != '0) begin
            cd_nxt = cooldown - CDW'(1);
        end else if (lfsr[1:0] == 2'd0) begin
            cd_nxt = COOL0;
        end else if (first_free != '0) begin
            cd_nxt = COOL0 + CDW'(lfsr[7:3]);
            for (int i = 0; i < NOBS; i++) begin
                if (first_free[i]) begin
                    act_nxt[i]  = 1'b1;
                    x_nxt[i]    = SPAWN_X;
                    lane_nxt[i] = lfsr[1:0];
                end
            end
        end else begin
            cd_nxt = '0;
        end
        score_sum = {1'b0, score} + 17'(retire_cnt);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NOBS; i++) begin
                slot_x[i]    <= '0;
                slot_lane[i] <= '0;
            end
            obs_active <= '0;
            phase      <= '0;
            lfsr       <= SEED;
            cooldown   <= COOL0;
            score      <= '0;
        end else if (game_restart) begin
            for (int i = 0; i < NOBS; i++) begin
                slot_x[i]    <= '0;
                slot_lane[i] <= '0;
            end
            obs_active <= '0;
            phase      <= '0;
            cooldown   <= COOL0;
            score      <= '0;
        end else if (frame_upd) begin
            slot_x     <= x_nxt;
            slot_lane  <= lane_nxt;
            obs_active <= act_nxt;
            phase      <= phase - step[2:0];
            lfsr       <= lfsr_nxt;
            cooldown   <= cd_nxt;
            score      <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            level_pix <= '0;
        end else if (!game_run) begin
            level_pix <= '0;
        end else if (obs_match) begin
            level_pix <= obs_col;
        end else if (in_cols && ground_on) begin
            level_pix <= GROUND_COL;
        end else begin
            level_pix <= '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hit <= 1'b0;
        end else if (game_restart) begin
            hit <= 1'b0;
        end else if (game_run && obs_match && (player_pix != '0)) begin
            hit <= 1'b1;
        end
    end

endmodule

// File: tb/tb_level_scroller.sv
module tb_level_scroller;
    localparam int          NOBS    = 2;
    localparam int          COOLMIN = 2;
    localparam logic [15:0] SEED    = 16'h0001;
    localparam int          XL = 170;
    localparam int          XR = 750;
    localparam int          GY = 308;
    localparam int          OW = 16;
    localparam int          OH = 24;

    logic            Clk = 1'b0;
    logic            Reset = 1'b0;
    logic            frame_tick = 1'b0;
    logic            game_run = 1'b0;
    logic            game_restart = 1'b0;
    logic [2:0]      speed = 3'd0;
    logic [9:0]      hc = '0;
    logic [9:0]      vc = '0;
    logic [3:0]      player_pix = '0;
    logic [3:0]      level_pix;
    logic            hit;
    logic [15:0]     score;
    logic [NOBS-1:0] obs_active;

    level_scroller #(
        .CIDXW(3), .CORDW(10), .NOBS(NOBS), .GROUND_Y(GY), .X_LEFT(XL),
        .X_RIGHT(XR), .OBS_W(OW), .OBS_H(OH), .COOLMIN(COOLMIN), .SEED(SEED)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .game_run(game_run),
        .game_restart(game_restart), .speed(speed), .hc(hc), .vc(vc),
        .player_pix(player_pix), .level_pix(level_pix), .hit(hit),
        .score(score), .obs_active(obs_active)
    );

    always #5 Clk = ~Clk;

    // Reference model state
    int          m_x    [NOBS];
    int          m_lane [NOBS];
    bit          m_act  [NOBS];
    int          m_phase;
    int          m_cd;
    int          m_score;
    logic [15:0] m_lfsr;
    bit          m_hit;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_pix;

    function automatic logic [NOBS-1:0] m_act_vec();
        logic [NOBS-1:0] v;
        v = '0;
        for (int i = 0; i < NOBS; i++) v[i] = m_act[i];
        return v;
    endfunction

    function automatic int lane_top(int lane);
        return GY - lane*OH;
    endfunction

    function automatic int m_obs_col(int h, int v);
        if (h < XL || h > XR) return 0;
        for (int i = 0; i < NOBS; i++) begin
            if (m_act[i] && h >= m_x[i] && h <= m_x[i] + OW - 1 &&
                v >= lane_top(m_lane[i]) && v <= lane_top(m_lane[i]) + OH - 1)
                return 3 + m_lane[i];
        end
        return 0;
    endfunction

    function automatic int m_pix(int h, int v);
        int c;
        if (!game_run) return 0;
        c = m_obs_col(h, v);
        if (c != 0) return c;
        if (h < XL || h > XR) return 0;
        if (v == GY) return ((h % 8) == m_phase) ? 7 : 0;
        if (v == GY + 1) return ((h % 8) != m_phase) ? 7 : 0;
        return 0;
    endfunction

    function automatic int vis_slot();
        for (int i = 0; i < NOBS; i++)
            if (m_act[i] && m_x[i] >= XL && m_x[i] <= XR) return i;
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NOBS; i++) begin
            m_x[i] = 0; m_lane[i] = 0; m_act[i] = 0;
        end
        m_phase = 0; m_cd = COOLMIN; m_score = 0; m_lfsr = SEED; m_hit = 0;
    endtask

    task automatic m_restart();
        for (int i = 0; i < NOBS; i++) begin
            m_x[i] = 0; m_lane[i] = 0; m_act[i] = 0;
        end
        m_phase = 0; m_cd = COOLMIN; m_score = 0; m_hit = 0;
    endtask

    task automatic m_frame();
        int          st;
        int          fi;
        logic [15:0] old_l;
        bit          old_act [NOBS];
        st      = int'(speed) + 1;
        old_l   = m_lfsr;
        old_act = m_act;
        m_phase = (m_phase - st + 8) % 8;
        m_lfsr  = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        for (int i = 0; i < NOBS; i++) begin
            if (old_act[i]) begin
                if (m_x[i] < XL + st) begin
                    m_act[i] = 0;
                    if (m_score < 65535) m_score++;
                end else begin
                    m_x[i] -= st;
                end
            end
        end
        if (m_cd != 0) begin
            m_cd--;
        end else if (old_l[1:0] == 2'd0) begin
            m_cd = COOLMIN;
        end else begin
            fi = -1;
            for (int i = NOBS-1; i >= 0; i--) if (!old_act[i]) fi = i;
            if (fi >= 0) begin
                m_act[fi] = 1; m_x[fi] = XR; m_lane[fi] = int'(old_l[1:0]);
                m_cd = COOLMIN + int'(old_l[7:3]);
            end else begin
                m_cd = 0;
            end
        end
    endtask

    task automatic tick_clk();
        @(posedge Clk);
        #1;
    endtask

    // Drive a pixel position and queue the pixel the model expects for it.
    task automatic probe(int h, int v);
        hc = 10'(h);
        vc = 10'(v);
        exp_q.push_back(4'(m_pix(h, v)));
        if (game_run && !game_restart && m_obs_col(h, v) != 0 && player_pix != 0) m_hit = 1;
        tick_clk();
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        if (game_run && !game_restart && m_obs_col(int'(hc), int'(vc)) != 0 && player_pix != 0)
            m_hit = 1;
        if (game_run && !game_restart) m_frame();
        tick_clk();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; game_run = 1'b1; hc = 10'd173; vc = 10'd308; player_pix = 4'd3;
        repeat (3) tick_clk();
        total_cnt++; if (level_pix !== 4'd0) $display("FAIL reset_pix: got %0d want 0", level_pix); else pass_cnt++;
        total_cnt++; if (hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", hit); else pass_cnt++;
        total_cnt++; if (score !== 16'd0) $display("FAIL reset_score: got %0d want 0", score); else pass_cnt++;
        total_cnt++; if (obs_active !== '0) $display("FAIL reset_active: got %b want 0", obs_active); else pass_cnt++;
        #2 Reset = 1'b1;
        game_run = 1'b0; player_pix = 4'd0;
        m_reset();
        repeat (10) frame();
        probe(173, GY);
        exp_pix = exp_q.pop_front();
        total_cnt++; if (level_pix !== exp_pix) $display("FAIL idle_pix: got %0d want %0d", level_pix, exp_pix); else pass_cnt++;
        total_cnt++; if (obs_active !== m_act_vec()) $display("FAIL idle_active: got %b want %b", obs_active, m_act_vec()); else pass_cnt++;
        total_cnt++; if (score !== 16'(m_score)) $display("FAIL idle_score: got %0d want %0d", score, m_score); else pass_cnt++;
    endtask

    task automatic test_ground();
        int hs [7] = '{173, 172, 173, 172, 169, 751, 176};
        int vs [7] = '{308, 308, 309, 309, 308, 308, 300};
        game_run = 1'b1; speed = 3'd0;
        repeat (3) frame();
        for (int k = 0; k < 7; k++) begin
            probe(hs[k], vs[k]);
            exp_pix = exp_q.pop_front();
            total_cnt++;
            if (level_pix !== exp_pix) $display("FAIL ground[%0d] hc=%0d vc=%0d: got %0d want %0d", k, hs[k], vs[k], level_pix, exp_pix);
            else pass_cnt++;
        end
    endtask

    task automatic test_spawn();
        int n = 0;
        int tp;
        while (m_act_vec() == '0 && n < 100) begin
            frame(); n++;
            total_cnt++;
            if (obs_active !== m_act_vec()) $display("FAIL spawn_active: got %b want %b", obs_active, m_act_vec());
            else pass_cnt++;
        end
        if (n >= 100) begin
            total_cnt++; $display("FAIL spawn_timeout: got no spawn want spawn within 100 frames");
        end
        for (int i = 0; i < NOBS; i++) begin
            if (m_act[i]) begin
                tp = lane_top(m_lane[i]);
                probe(m_x[i], tp);
                exp_pix = exp_q.pop_front();
                total_cnt++; if (level_pix !== exp_pix) $display("FAIL spawn_lane_pix: got %0d want %0d", level_pix, exp_pix); else pass_cnt++;
                probe(m_x[i] - 1, tp);
                exp_pix = exp_q.pop_front();
                total_cnt++; if (level_pix !== exp_pix) $display("FAIL spawn_left_edge: got %0d want %0d", level_pix, exp_pix); else pass_cnt++;
                probe(m_x[i] + OW - 1, tp + OH - 1);
                exp_pix = exp_q.pop_front();
                total_cnt++; if (level_pix !== exp_pix) $display("FAIL spawn_clip: got %0d want %0d", level_pix, exp_pix); else pass_cnt++;
                probe(m_x[i], tp - 1);
                exp_pix = exp_q.pop_front();
                total_cnt++; if (level_pix !== exp_pix) $display("FAIL spawn_above: got %0d want %0d", level_pix, exp_pix); else pass_cnt++;
            end
        end
    endtask

    task automatic test_scroll_retire();
        int n = 0;
        int start = m_score;
        speed = 3'd7;
        while (m_score < start + 3 && n < 400) begin
            frame(); n++;
            total_cnt++; if (obs_active !== m_act_vec()) $display("FAIL scroll_active: got %b want %b", obs_active, m_act_vec()); else pass_cnt++;
            total_cnt++; if (score !== 16'(m_score)) $display("FAIL scroll_score: got %0d want %0d", score, m_score); else pass_cnt++;
            if (m_act[0]) begin
                probe(m_x[0], lane_top(m_lane[0]));
                exp_pix = exp_q.pop_front();
                total_cnt++; if (level_pix !== exp_pix) $display("FAIL scroll_x0: got %0d want %0d", level_pix, exp_pix); else pass_cnt++;
                probe(m_x[0] - 1, lane_top(m_lane[0]));
                exp_pix = exp_q.pop_front();
                total_cnt++; if (level_pix !== exp_pix) $display("FAIL scroll_x0m1: got %0d want %0d", level_pix, exp_pix); else pass_cnt++;
            end
        end
        if (n >= 400) begin
            total_cnt++; $display("FAIL retire_timeout: got %0d retirements want 3", m_score - start);
        end
    endtask

    task automatic test_hit();
        int n = 0;
        int s;
        player_pix = 4'd3;
        probe(173, GY);
        exp_pix = exp_q.pop_front();
        total_cnt++; if (level_pix !== exp_pix) $display("FAIL nohit_pix: got %0d want %0d", level_pix, exp_pix); else pass_cnt++;
        total_cnt++; if (hit !== m_hit) $display("FAIL nohit: got %b want %b", hit, m_hit); else pass_cnt++;
        player_pix = 4'd0;
        while (vis_slot() < 0 && n < 200) begin
            frame(); n++;
        end
        s = vis_slot();
        if (s < 0) begin
            total_cnt++; $display("FAIL hit_timeout: got no visible obstacle want one within 200 frames");
        end else begin
            player_pix = 4'd3;
            probe(m_x[s], lane_top(m_lane[s]) + 5);
            exp_pix = exp_q.pop_front();
            total_cnt++; if (level_pix !== exp_pix) $display("FAIL hit_pix: got %0d want %0d", level_pix, exp_pix); else pass_cnt++;
            total_cnt++; if (hit !== m_hit) $display("FAIL hit_set: got %b want %b", hit, m_hit); else pass_cnt++;
            player_pix = 4'd0;
            probe(173, 100);
            exp_pix = exp_q.pop_front();
            repeat (3) tick_clk();
            total_cnt++; if (hit !== m_hit) $display("FAIL hit_sticky: got %b want %b", hit, m_hit); else pass_cnt++;
        end
    endtask

    task automatic test_freeze();
        int s = vis_slot();
        game_run = 1'b0;
        repeat (5) frame();
        total_cnt++; if (obs_active !== m_act_vec()) $display("FAIL freeze_active: got %b want %b", obs_active, m_act_vec()); else pass_cnt++;
        total_cnt++; if (score !== 16'(m_score)) $display("FAIL freeze_score: got %0d want %0d", score, m_score); else pass_cnt++;
        if (s >= 0) begin
            probe(m_x[s], lane_top(m_lane[s]));
            exp_pix = exp_q.pop_front();
            total_cnt++; if (level_pix !== exp_pix) $display("FAIL freeze_pix: got %0d want %0d", level_pix, exp_pix); else pass_cnt++;
            game_run = 1'b1;
            probe(m_x[s], lane_top(m_lane[s]));
            exp_pix = exp_q.pop_front();
            total_cnt++; if (level_pix !== exp_pix) $display("FAIL freeze_hold_x: got %0d want %0d", level_pix, exp_pix); else pass_cnt++;
        end
        game_run = 1'b1;
    endtask

    task automatic test_restart();
        int n = 0;
        game_restart = 1'b1; frame_tick = 1'b1;
        m_restart();
        tick_clk();
        game_restart = 1'b0; frame_tick = 1'b0;
        total_cnt++; if (hit !== m_hit) $display("FAIL restart_hit: got %b want %b", hit, m_hit); else pass_cnt++;
        total_cnt++; if (score !== 16'(m_score)) $display("FAIL restart_score: got %0d want %0d", score, m_score); else pass_cnt++;
        total_cnt++; if (obs_active !== m_act_vec()) $display("FAIL restart_active: got %b want %b", obs_active, m_act_vec()); else pass_cnt++;
        speed = 3'd2;
        while (m_act_vec() == '0 && n < 100) begin
            frame(); n++;
            total_cnt++; if (obs_active !== m_act_vec()) $display("FAIL restart_spawn: got %b want %b", obs_active, m_act_vec()); else pass_cnt++;
        end
        if (n >= 100) begin
            total_cnt++; $display("FAIL restart_timeout: got no spawn want spawn within 100 frames");
        end
        for (int i = 0; i < NOBS; i++) begin
            if (m_act[i]) begin
                probe(m_x[i], lane_top(m_lane[i]));
                exp_pix = exp_q.pop_front();
                total_cnt++; if (level_pix !== exp_pix) $display("FAIL restart_lane: got %0d want %0d", level_pix, exp_pix); else pass_cnt++;
            end
        end
    endtask

    task automatic test_async_reset();
        Reset = 1'b0;
        #2;
        total_cnt++; if (level_pix !== 4'd0) $display("FAIL async_pix: got %0d want 0", level_pix); else pass_cnt++;
        total_cnt++; if (obs_active !== '0) $display("FAIL async_active: got %b want 0", obs_active); else pass_cnt++;
        m_reset();
        tick_clk();
        Reset = 1'b1;
        speed = 3'd0;
        for (int k = 0; k < 20; k++) begin
            frame();
            total_cnt++; if (obs_active !== m_act_vec()) $display("FAIL post_reset_active[%0d]: got %b want %b", k, obs_active, m_act_vec()); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_ground();
        test_spawn();
        test_scroll_retire();
        test_hit();
        test_freeze();
        test_restart();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
